dmem_arbiter: RTL and testbench

- Two-master arbiter for the single-port data RAM (byte-write-enabled, 1-cycle synchronous read).
- Master 0 is the CPU data port (dce/daddr/we/din/dm style); master 1 is a secondary requester (DMA/debug loader) with a req/gnt handshake.
- CPU has default priority. A starvation counter and a bounded lock window guarantee forward progress for both masters.
- Sits between the CPU top-level data port and the RAM instance.

---
 rtl/dmem_arbiter_pkg.sv | 23 ++
 rtl/dmem_arbiter_sat_counter.sv | 42 ++++
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter.
//   - default parameter values (RAM address width, starvation and burst limits)
//   - owner_e : which master a pending RAM read belongs to
//   - state_e : arbiter FSM state (the master granted last cycle)
package dmem_arbiter_pkg;

    localparam int DEF_AW        = 10;
    localparam int DEF_MAX_WAIT  = 4;
    localparam int DEF_MAX_BURST = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_M0   = 2'd1,
        ST_M1   = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : clear to zero (wins over inc_i)
//   inc_i     : count up by one, holding at MAX
//   cnt_o     : current count
module arb_sat_counter #(
    parameter int W   = 3,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port data RAM.
// Master 0 is the CPU data port and has default priority; master 1 is a
// DMA/debug requester. A starvation counter (wait_cnt) forces m1 through after
// MAX_WAIT denied cycles; a lock window lets m1 hold the RAM for up to
// MAX_BURST consecutive cycles before the CPU gets one forced slot.
//
// Handshake: a request is held high until it is served. m0 is served in any
// cycle where m0_req=1 and m0_stall=0; m1 is served in any cycle where
// m1_gnt=1. Service is combinational in the request cycle; read data appears
// on m0_rdata/m1_rdata the following cycle, flagged by m1_rvalid for m1.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   m0_*                : CPU request/we/addr/wdata in, rdata/stall out
//   m1_*                : master-1 request/lock/we/addr/wdata in,
//                         gnt/rvalid/rdata out
//   ram_*               : RAM enable/we/addr/din out, dout in
//   dbg_*_o             : FSM state, counters and read owner for observation
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             m0_req,
    input  logic [3:0]                       m0_we,
    input  logic [31:0]                      m0_addr,
    input  logic [31:0]                      m0_wdata,
    output logic [31:0]                      m0_rdata,
    output logic                             m0_stall,
    input  logic                             m1_req,
    input  logic                             m1_lock,
    input  logic [3:0]                       m1_we,
    input  logic [31:0]                      m1_addr,
    input  logic [31:0]                      m1_wdata,
    output logic                             m1_gnt,
    output logic                             m1_rvalid,
    output logic [31:0]                      m1_rdata,
    output logic                             ram_ena,
    output logic [3:0]                       ram_we,
    output logic [AW-1:0]                    ram_addr,
    output logic [31:0]                      ram_din,
    input  logic [31:0]                      ram_dout,
    output state_e                           dbg_state_o,
    output logic [$clog2(MAX_WAIT+1)-1:0]    dbg_wait_cnt_o,
    output logic [$clog2(MAX_BURST)-1:0]     dbg_burst_cnt_o,
    output owner_e                           dbg_rd_owner_o
);

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(MAX_BURST);
    localparam logic [WAIT_W-1:0]  WAIT_SAT  = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST - 1);

    state_e              state_q, state_d;
    owner_e              rd_owner_q, rd_owner_d;
    logic                gnt0, gnt1;
    logic                starve, keep_burst;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [BURST_W-1:0]  burst_cnt;

    // Address bits above the RAM word range are not decoded here.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{m0_addr[31:AW], m1_addr[31:AW]};

    // Grant decision and next state.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        starve     = m1_req && (wait_cnt == WAIT_SAT);
        // burst_cnt counts continuation grants only (state already M1), so the
        // first grant plus MAX_BURST-1 continuations give MAX_BURST cycles.
        keep_burst = (state_q == ST_M1) && m1_req && m1_lock &&
                     (burst_cnt < BURST_LIM);
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (keep_burst) begin
            gnt1 = 1'b1;
        end else if (m0_req && !starve) begin
            gnt0 = 1'b1;
        end else if (m1_req) begin
            gnt1 = 1'b1;
        end

        if (gnt0) begin
            state_d = ST_M0;
        end else if (gnt1) begin
            state_d = ST_M1;
        end else begin
            state_d = ST_IDLE;
        end

        rd_owner_d = OWN_NONE;
        if (gnt0 && (m0_we == 4'h0)) begin
            rd_owner_d = OWN_M0;
        end else if (gnt1 && (m1_we == 4'h0)) begin
            rd_owner_d = OWN_M1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_owner_q <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    arb_sat_counter #(.W(WAIT_W), .MAX(MAX_WAIT)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (gnt1 || !m1_req),
        .inc_i (m1_req && !gnt1),
        .cnt_o (wait_cnt)
    );

    arb_sat_counter #(.W(BURST_W), .MAX(MAX_BURST - 1)) u_burst_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!gnt1),
        .inc_i (gnt1 && (state_q == ST_M1)),
        .cnt_o (burst_cnt)
    );

    // RAM mux follows the grant in the same cycle.
    always_comb begin
        ram_ena  = gnt0 || gnt1;
        ram_we   = 4'h0;
        ram_addr = m0_addr[AW-1:0];
        ram_din  = m0_wdata;
        if (gnt1) begin
            ram_we   = m1_we;
            ram_addr = m1_addr[AW-1:0];
            ram_din  = m1_wdata;
        end else if (gnt0) begin
            ram_we   = m0_we;
        end
    end

    assign m0_stall  = m0_req && !gnt0 && !rst;
    assign m0_rdata  = ram_dout;
    assign m1_gnt    = gnt1;
    assign m1_rdata  = ram_dout;
    // A read in flight when reset arrives is dropped immediately.
    assign m1_rvalid = (rd_owner_q == OWN_M1) && !rst;

    assign dbg_state_o     = state_q;
    assign dbg_wait_cnt_o  = wait_cnt;
    assign dbg_burst_cnt_o = burst_cnt;
    assign dbg_rd_owner_o  = rd_owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req, m1_req, m1_lock;
    logic [3:0]  m0_we, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata, ram_din, ram_dout;
    logic        m0_stall, m1_gnt, m1_rvalid, ram_ena;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    state_e      dbg_state;
    logic [2:0]  dbg_wait_cnt, dbg_burst_cnt;
    owner_e      dbg_rd_owner;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_ena(ram_ena), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout),
        .dbg_state_o(dbg_state), .dbg_wait_cnt_o(dbg_wait_cnt),
        .dbg_burst_cnt_o(dbg_burst_cnt), .dbg_rd_owner_o(dbg_rd_owner)
    );

    // Byte-write RAM with registered read.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_ena) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end
            if (ram_we == 4'h0) ram_dout <= mem[ram_addr];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        m0_req = 1'b0; m0_we = 4'h0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_lock = 1'b0; m1_we = 4'h0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1; m1_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (ram_ena !== 1'b0) begin n_err++; $display("FAIL reset_ram_ena[%0d]: got %b want 0", i, ram_ena); end
            n_cmp++; if (m1_gnt !== 1'b0) begin n_err++; $display("FAIL reset_m1_gnt[%0d]: got %b want 0", i, m1_gnt); end
            n_cmp++; if (m0_stall !== 1'b0) begin n_err++; $display("FAIL reset_m0_stall[%0d]: got %b want 0", i, m0_stall); end
            n_cmp++; if (m1_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_m1_rvalid[%0d]: got %b want 0", i, m1_rvalid); end
        end
        next_cycle();
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL post_reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        n_cmp++; if (dbg_wait_cnt !== 3'd0) begin n_err++; $display("FAIL post_reset_wait_cnt: got %0d want 0", dbg_wait_cnt); end
        n_cmp++; if (dbg_burst_cnt !== 3'd0) begin n_err++; $display("FAIL post_reset_burst_cnt: got %0d want 0", dbg_burst_cnt); end
        n_cmp++; if (dbg_rd_owner !== OWN_NONE) begin n_err++; $display("FAIL post_reset_rd_owner: got %0d want 0", dbg_rd_owner); end
        n_cmp++; if (ram_ena !== 1'b0) begin n_err++; $display("FAIL post_reset_ram_ena: got %b want 0", ram_ena); end
        next_cycle();
    endtask

    task automatic test_cpu_only();
        m0_req = 1'b1; m0_we = 4'hF; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++; if (ram_ena !== 1'b1) begin n_err++; $display("FAIL cpu_wr_ena: got %b want 1", ram_ena); end
        n_cmp++; if (ram_we !== 4'hF) begin n_err++; $display("FAIL cpu_wr_we: got %h want f", ram_we); end
        n_cmp++; if (ram_addr !== 10'h010) begin n_err++; $display("FAIL cpu_wr_addr: got %h want 010", ram_addr); end
        n_cmp++; if (ram_din !== 32'hDEADBEEF) begin n_err++; $display("FAIL cpu_wr_din: got %h want deadbeef", ram_din); end
        n_cmp++; if (m0_stall !== 1'b0) begin n_err++; $display("FAIL cpu_wr_stall: got %b want 0", m0_stall); end
        n_cmp++; if (m1_gnt !== 1'b0) begin n_err++; $display("FAIL cpu_wr_m1_gnt: got %b want 0", m1_gnt); end
        next_cycle();
        m0_we = 4'h0;
        @(negedge clk);
        n_cmp++; if (ram_we !== 4'h0) begin n_err++; $display("FAIL cpu_rd_we: got %h want 0", ram_we); end
        n_cmp++; if (ram_addr !== 10'h010) begin n_err++; $display("FAIL cpu_rd_addr: got %h want 010", ram_addr); end
        n_cmp++; if (m0_stall !== 1'b0) begin n_err++; $display("FAIL cpu_rd_stall: got %b want 0", m0_stall); end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_cmp++; if (m0_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL cpu_rd_data: got %h want deadbeef", m0_rdata); end
        n_cmp++; if (m1_rvalid !== 1'b0) begin n_err++; $display("FAIL cpu_rd_m1_rvalid: got %b want 0", m1_rvalid); end
        n_cmp++; if (dbg_rd_owner !== OWN_M0) begin n_err++; $display("FAIL cpu_rd_owner: got %0d want 1", dbg_rd_owner); end
        next_cycle();
    endtask

    task automatic test_m1_read();
        m0_req = 1'b1; m0_we = 4'hF; m0_addr = 32'h20; m0_wdata = 32'h12345678;
        next_cycle();
        drive_idle();
        m1_req = 1'b1; m1_we = 4'h0; m1_addr = 32'h20;
        @(negedge clk);
        n_cmp++; if (m1_gnt !== 1'b1) begin n_err++; $display("FAIL m1_rd_gnt: got %b want 1", m1_gnt); end
        n_cmp++; if (ram_addr !== 10'h020) begin n_err++; $display("FAIL m1_rd_addr: got %h want 020", ram_addr); end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_cmp++; if (m1_rvalid !== 1'b1) begin n_err++; $display("FAIL m1_rd_rvalid_t1: got %b want 1", m1_rvalid); end
        n_cmp++; if (m1_rdata !== 32'h12345678) begin n_err++; $display("FAIL m1_rd_data: got %h want 12345678", m1_rdata); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (m1_rvalid !== 1'b0) begin n_err++; $display("FAIL m1_rd_rvalid_t2: got %b want 0", m1_rvalid); end
        next_cycle();
        // Partial byte write from m1, then read back the merged word.
        m1_req = 1'b1; m1_we = 4'b0011; m1_addr = 32'h20; m1_wdata = 32'hAAAA5555;
        @(negedge clk);
        n_cmp++; if (ram_we !== 4'b0011) begin n_err++; $display("FAIL m1_wr_we: got %h want 3", ram_we); end
        n_cmp++; if (ram_din !== 32'hAAAA5555) begin n_err++; $display("FAIL m1_wr_din: got %h want aaaa5555", ram_din); end
        next_cycle();
        m1_we = 4'h0;
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_cmp++; if (m1_rdata !== 32'h12345555) begin n_err++; $display("FAIL m1_byte_merge: got %h want 12345555", m1_rdata); end
        next_cycle();
    endtask

    task automatic test_contention();
        m0_req = 1'b1; m0_we = 4'h0; m0_addr = 32'h10;
        m1_req = 1'b1; m1_we = 4'h0; m1_addr = 32'h20;
        for (int i = 0; i < 10; i++) begin
            logic exp_g1;
            logic exp_rv;
            exp_g1 = ((i % 5) == 4);
            exp_rv = ((i % 5) == 0) && (i != 0);
            @(negedge clk);
            n_cmp++; if (m1_gnt !== exp_g1) begin n_err++; $display("FAIL cont_m1_gnt[%0d]: got %b want %b", i, m1_gnt, exp_g1); end
            n_cmp++; if (m0_stall !== exp_g1) begin n_err++; $display("FAIL cont_m0_stall[%0d]: got %b want %b", i, m0_stall, exp_g1); end
            n_cmp++; if (ram_addr !== (exp_g1 ? 10'h020 : 10'h010)) begin n_err++; $display("FAIL cont_addr[%0d]: got %h", i, ram_addr); end
            n_cmp++; if (dbg_wait_cnt !== 3'(i % 5)) begin n_err++; $display("FAIL cont_wait_cnt[%0d]: got %0d want %0d", i, dbg_wait_cnt, i % 5); end
            n_cmp++; if (m1_rvalid !== exp_rv) begin n_err++; $display("FAIL cont_m1_rvalid[%0d]: got %b want %b", i, m1_rvalid, exp_rv); end
            next_cycle();
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_burst();
        logic [2:0] exp_burst [12] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
                                       3'd5, 3'd6, 3'd7, 3'd0, 3'd0, 3'd1};
        logic m0_done;
        m0_done = 1'b0;
        m1_req = 1'b1; m1_lock = 1'b1; m1_we = 4'hF; m1_addr = 32'h30;
        m0_we = 4'h0; m0_addr = 32'h10;
        for (int c = 0; c < 12; c++) begin
            logic exp_g1;
            logic exp_g0;
            m1_wdata = 32'(c);
            m0_req = (c >= 1) && !m0_done;
            exp_g0 = (c == 8);
            exp_g1 = !exp_g0;
            @(negedge clk);
            n_cmp++; if (m1_gnt !== exp_g1) begin n_err++; $display("FAIL burst_m1_gnt[%0d]: got %b want %b", c, m1_gnt, exp_g1); end
            n_cmp++; if (m0_stall !== (m0_req && !exp_g0)) begin n_err++; $display("FAIL burst_m0_stall[%0d]: got %b want %b", c, m0_stall, m0_req && !exp_g0); end
            n_cmp++; if (dbg_burst_cnt !== exp_burst[c]) begin n_err++; $display("FAIL burst_cnt[%0d]: got %0d want %0d", c, dbg_burst_cnt, exp_burst[c]); end
            if (exp_g0) m0_done = 1'b1;
            next_cycle();
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        m1_req = 1'b1; m1_lock = 1'b1; m1_we = 4'h0; m1_addr = 32'h20;
        for (int c = 0; c < 3; c++) next_cycle();
        @(negedge clk);
        n_cmp++; if (m1_gnt !== 1'b1) begin n_err++; $display("FAIL rmr_gnt_t: got %b want 1", m1_gnt); end
        n_cmp++; if (dbg_burst_cnt !== 3'd2) begin n_err++; $display("FAIL rmr_burst_t: got %0d want 2", dbg_burst_cnt); end
        next_cycle();
        rst = 1'b1;
        m0_req = 1'b1;
        @(negedge clk);
        n_cmp++; if (m1_rvalid !== 1'b0) begin n_err++; $display("FAIL rmr_rvalid_t1: got %b want 0", m1_rvalid); end
        n_cmp++; if (m1_gnt !== 1'b0) begin n_err++; $display("FAIL rmr_gnt_t1: got %b want 0", m1_gnt); end
        n_cmp++; if (m0_stall !== 1'b0) begin n_err++; $display("FAIL rmr_stall_t1: got %b want 0", m0_stall); end
        n_cmp++; if (ram_ena !== 1'b0) begin n_err++; $display("FAIL rmr_ena_t1: got %b want 0", ram_ena); end
        next_cycle();
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        n_cmp++; if (m1_rvalid !== 1'b0) begin n_err++; $display("FAIL rmr_rvalid_t2: got %b want 0", m1_rvalid); end
        n_cmp++; if (dbg_burst_cnt !== 3'd0) begin n_err++; $display("FAIL rmr_burst_t2: got %0d want 0", dbg_burst_cnt); end
        n_cmp++; if (dbg_wait_cnt !== 3'd0) begin n_err++; $display("FAIL rmr_wait_t2: got %0d want 0", dbg_wait_cnt); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rmr_state_t2: got %0d want 0", dbg_state); end
        n_cmp++; if (dbg_rd_owner !== OWN_NONE) begin n_err++; $display("FAIL rmr_owner_t2: got %0d want 0", dbg_rd_owner); end
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive_idle();
        test_reset();
        test_cpu_only();
        test_m1_read();
        test_contention();
        test_burst();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
